// File: rtl/ifu_thrsched_pkg.sv
// Shared types and helpers for the IFU thread switch scheduler.
package ifu_thrsched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SWITCH = 2'b01,
    RUN    = 2'b10,
    DRAIN  = 2'b11
  } thr_state_e;

  localparam int unsigned QCW = 8;

  // Width of an encoded thread index; at least one bit.
  function automatic int unsigned thr_w(input int unsigned n);
    if (n <= 2) return 1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sparc_ifu_thrsched_rrpick.sv
// Two-level round-robin picker: ready threads first, speculative-ready only as fallback.
module sparc_ifu_thrsched_rrpick
  import ifu_thrsched_pkg::*;
#(
  parameter  int unsigned NTHR = 4,
  localparam int unsigned TW   = thr_w(NTHR)
) (
  input  logic [NTHR-1:0] rdy,
  input  logic [NTHR-1:0] spec,
  input  logic [TW-1:0]   ptr,
  output logic [TW-1:0]   win_c,
  output logic            found_c
);

  logic          rdy_hit;
  logic          spec_hit;
  logic [TW-1:0] rdy_idx;
  logic [TW-1:0] spec_idx;

  // Scan from ptr+1 upward, wrapping, keeping the first hit at each level.
  always_comb begin
    rdy_hit  = 1'b0;
    spec_hit = 1'b0;
    rdy_idx  = '0;
    spec_idx = '0;
    for (int unsigned i = 1; i <= NTHR; i++) begin
      if (!rdy_hit && rdy[TW'((32'(ptr) + i) % NTHR)]) begin
        rdy_hit = 1'b1;
        rdy_idx = TW'((32'(ptr) + i) % NTHR);
      end
      if (!spec_hit && spec[TW'((32'(ptr) + i) % NTHR)]) begin
        spec_hit = 1'b1;
        spec_idx = TW'((32'(ptr) + i) % NTHR);
      end
    end
  end

  assign win_c   = rdy_hit ? rdy_idx : spec_idx;
  assign found_c = rdy_hit | spec_hit;

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// Per-core IFU thread switch scheduler: picks a thread, pulses schedule, enforces a run quantum.
module sparc_ifu_thrsched
  import ifu_thrsched_pkg::*;
#(
  parameter  int unsigned NTHR    = 4,
  parameter  int unsigned QUANTUM = 8,
  localparam int unsigned TW      = thr_w(NTHR)
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic [NTHR-1:0] thr_rdy,
  input  logic [NTHR-1:0] thr_spec_rdy,
  input  logic [NTHR-1:0] thr_run,
  input  logic            hold,
  input  logic            force_sw,
  output logic [NTHR-1:0] schedule,
  output logic            switch_out,
  output logic [TW-1:0]   cur_thr,
  output logic            cur_vld
);

  localparam logic [QCW-1:0] QMAX = QCW'(QUANTUM - 1);

  thr_state_e      state_q, state_d;
  logic [QCW-1:0]  qcnt_q, qcnt_d;
  logic [TW-1:0]   ptr_q, ptr_d;
  logic [NTHR-1:0] schedule_q, schedule_d;
  logic            switch_out_q, switch_out_d;
  logic [TW-1:0]   cur_thr_q, cur_thr_d;
  logic            cur_vld_q, cur_vld_d;

  logic [NTHR-1:0] cand;
  logic [TW-1:0]   win_c;
  logic            found_c;
  logic            other_c;
  logic            sched_c;
  logic            swout_c;

  assign cand    = thr_rdy | thr_spec_rdy;
  assign other_c = |(cand & ~(NTHR'(1) << cur_thr_q));

  sparc_ifu_thrsched_rrpick #(.NTHR(NTHR)) u_rrpick (
    .rdy     (thr_rdy),
    .spec    (thr_spec_rdy),
    .ptr     (ptr_q),
    .win_c   (win_c),
    .found_c (found_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q      <= IDLE;
      qcnt_q       <= '0;
      ptr_q        <= TW'(NTHR - 1);
      schedule_q   <= '0;
      switch_out_q <= 1'b0;
      cur_thr_q    <= '0;
      cur_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      ptr_q        <= ptr_d;
      schedule_q   <= schedule_d;
      switch_out_q <= switch_out_d;
      cur_thr_q    <= cur_thr_d;
      cur_vld_q    <= cur_vld_d;
    end
  end

  // Next state; self-exit (run drop) outranks force_sw and quantum expiry.
  always_comb begin
    state_d = state_q;
    sched_c = 1'b0;
    swout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c && !hold) begin
          state_d = SWITCH;
          sched_c = 1'b1;
        end
      end
      SWITCH: begin
        if (thr_run[cur_thr_q])      state_d = RUN;
        else if (!cand[cur_thr_q])   state_d = IDLE;
      end
      RUN: begin
        if (!thr_run[cur_thr_q]) begin
          state_d = IDLE;
        end else if (!hold && (force_sw || (qcnt_q == QMAX && other_c))) begin
          state_d = DRAIN;
          swout_c = 1'b1;
        end
      end
      DRAIN: begin
        if (!thr_run[cur_thr_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output, pointer and quantum counter next values.
  always_comb begin
    schedule_d   = '0;
    switch_out_d = swout_c;
    cur_thr_d    = cur_thr_q;
    ptr_d        = ptr_q;
    cur_vld_d    = (state_d != IDLE);
    qcnt_d       = '0;
    if (sched_c) begin
      schedule_d = NTHR'(1) << win_c;
      cur_thr_d  = win_c;
      ptr_d      = win_c;
    end
    if (state_q == RUN) begin
      qcnt_d = (qcnt_q == QMAX) ? qcnt_q : qcnt_q + QCW'(1);
    end
  end

  assign schedule   = schedule_q;
  assign switch_out = switch_out_q;
  assign cur_thr    = cur_thr_q;
  assign cur_vld    = cur_vld_q;

  a_run_onehot: assert property (@(posedge clk) disable iff (!arst_l) $onehot0(thr_run))
    else $error("thr_run has more than one bit set: %b", thr_run);

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Directed bench for sparc_ifu_thrsched with NTHR=4, QUANTUM=8.
module tb_sparc_ifu_thrsched;

  logic       clk;
  logic       arst_l;
  logic [3:0] thr_rdy;
  logic [3:0] thr_spec_rdy;
  logic [3:0] thr_run;
  logic       hold;
  logic       force_sw;
  logic [3:0] schedule;
  logic       switch_out;
  logic [1:0] cur_thr;
  logic       cur_vld;

  int n_tests = 0;
  int n_fail  = 0;

  sparc_ifu_thrsched #(.NTHR(4), .QUANTUM(8)) dut (
    .clk          (clk),
    .arst_l       (arst_l),
    .thr_rdy      (thr_rdy),
    .thr_spec_rdy (thr_spec_rdy),
    .thr_run      (thr_run),
    .hold         (hold),
    .force_sw     (force_sw),
    .schedule     (schedule),
    .switch_out   (switch_out),
    .cur_thr      (cur_thr),
    .cur_vld      (cur_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic sw_seen;
    logic thr_moved;
    arst_l = 1'b0; thr_rdy = '0; thr_spec_rdy = '0; thr_run = '0; hold = 1'b0; force_sw = 1'b0;
    repeat (2) tick();
    chk("rst_schedule", 32'(schedule), 32'h0);
    chk("rst_switch_out", 32'(switch_out), 32'h0);
    chk("rst_cur_thr", 32'(cur_thr), 32'h0);
    chk("rst_cur_vld", 32'(cur_vld), 32'h0);

    // Test 1: first schedule, quantum expiry, reschedule.
    thr_rdy = 4'b0110; arst_l = 1'b1;
    tick();
    chk("t1_schedule", 32'(schedule), 32'h2);
    chk("t1_cur_thr", 32'(cur_thr), 32'h1);
    chk("t1_cur_vld", 32'(cur_vld), 32'h1);
    thr_rdy = 4'b0100; thr_run = 4'b0010;
    tick();
    chk("t1_sched_pulse_end", 32'(schedule), 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_no_early_switch", 32'(switch_out), 32'h0);
    end
    tick();
    chk("t1_quantum_switch", 32'(switch_out), 32'h1);
    chk("t1_vld_in_drain", 32'(cur_vld), 32'h1);
    thr_run = 4'b0000; thr_rdy = 4'b0110;
    tick();
    chk("t1_switch_pulse_end", 32'(switch_out), 32'h0);
    chk("t1_no_sched_in_drain", 32'(schedule), 32'h0);
    chk("t1_idle_vld", 32'(cur_vld), 32'h0);
    tick();
    chk("t1_resched", 32'(schedule), 32'h4);
    chk("t1_resched_thr", 32'(cur_thr), 32'h2);

    // Test 2: speculative fallback and ready priority.
    thr_rdy = 4'b0000; thr_spec_rdy = 4'b1000;
    tick();
    chk("t2_stall_to_idle", 32'(cur_vld), 32'h0);
    tick();
    chk("t2_spec_sched", 32'(schedule), 32'h8);
    chk("t2_spec_thr", 32'(cur_thr), 32'h3);
    thr_spec_rdy = 4'b0000;
    tick();
    thr_rdy = 4'b0001; thr_spec_rdy = 4'b1000;
    tick();
    chk("t2_rdy_beats_spec", 32'(schedule), 32'h1);
    thr_rdy = 4'b0000; thr_spec_rdy = 4'b0000;
    tick();
    thr_rdy = 4'b1000; thr_spec_rdy = 4'b0010;
    tick();
    chk("t2_rdy_beats_nearer_spec", 32'(schedule), 32'h8);
    thr_rdy = 4'b0000; thr_spec_rdy = 4'b0000;
    tick();

    // Test 3: a lone thread runs past many quanta.
    thr_rdy = 4'b0100;
    tick();
    chk("t3_sched", 32'(schedule), 32'h4);
    thr_run = 4'b0100;
    sw_seen = 1'b0; thr_moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      sw_seen   = sw_seen | switch_out;
      thr_moved = thr_moved | (cur_thr != 2'd2) | !cur_vld;
    end
    chk("t3_no_switch", 32'(sw_seen), 32'h0);
    chk("t3_thr_stays", 32'(thr_moved), 32'h0);

    // Test 4: hold defers a forced switch.
    force_sw = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_held", 32'(switch_out), 32'h0);
    end
    hold = 1'b0;
    tick();
    chk("t4_switch_after_hold", 32'(switch_out), 32'h1);
    force_sw = 1'b0;
    tick();
    chk("t4_single_pulse", 32'(switch_out), 32'h0);
    chk("t4_drain_vld", 32'(cur_vld), 32'h1);

    // Test 5: self-exit beats force_sw.
    thr_run = 4'b0000; thr_rdy = 4'b0000;
    tick();
    chk("t5_drain_exit", 32'(cur_vld), 32'h0);
    thr_rdy = 4'b0001;
    tick();
    chk("t5_sched0", 32'(schedule), 32'h1);
    thr_rdy = 4'b0000; thr_run = 4'b0001;
    tick();
    thr_rdy = 4'b1010;
    tick();
    thr_run = 4'b0000; force_sw = 1'b1;
    tick();
    chk("t5_no_switch_out", 32'(switch_out), 32'h0);
    chk("t5_idle", 32'(cur_vld), 32'h0);
    force_sw = 1'b0;
    tick();
    chk("t5_next_rr", 32'(schedule), 32'h2);
    chk("t5_next_thr", 32'(cur_thr), 32'h1);

    // Test 6: asynchronous reset during DRAIN.
    thr_rdy = 4'b1000; thr_run = 4'b0010;
    tick();
    force_sw = 1'b1;
    tick();
    chk("t6_switch", 32'(switch_out), 32'h1);
    force_sw = 1'b0;
    #2 arst_l = 1'b0;
    #1;
    chk("t6_async_switch_out", 32'(switch_out), 32'h0);
    chk("t6_async_cur_vld", 32'(cur_vld), 32'h0);
    chk("t6_async_cur_thr", 32'(cur_thr), 32'h0);
    chk("t6_async_schedule", 32'(schedule), 32'h0);
    thr_rdy = 4'b1111; thr_run = 4'b0000;
    tick();
    arst_l = 1'b1;
    tick();
    chk("t6_post_reset_sched", 32'(schedule), 32'h1);
    chk("t6_post_reset_thr", 32'(cur_thr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
